rd_pntr_empty: RTL and testbench

Read-side pointer and empty-flag controller for the dual-clock FIFO, running entirely in the read clock domain. It synchronizes the write pointer (Gray) into the read domain and maintains the binary/Gray read pointer. It generates the memory read address and enable, and produces registered empty, almost-empty, used-word and underflow status. Its Gray read pointer output is the value the write-side synchronizer carries into the write domain.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/rd_pntr_empty_if.sv | 22 ++
 rtl/sync_w2r.sv | 27 ++
 rtl/rd_pntr_empty.sv | 76 +++++++
 tb/tb_rd_pntr_empty.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO helpers: Gray/binary pointer conversion and default sizing.
package fifo_pkg;

    localparam int unsigned AWIDTH_DEFAULT = 3;
    localparam int unsigned PTR_MAX_W      = 16;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended inputs convert correctly, so callers may truncate back to their width.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rd_pntr_empty_if.sv
// Consumer-facing read handshake and status bundle of the FIFO read controller.
interface rd_pntr_empty_if #(
    parameter int unsigned AWIDTH = 3
);
    logic              rd_req_i;
    logic              rd_en_o;
    logic [AWIDTH-1:0] rd_addr_o;
    logic              rd_empty_o;
    logic              rd_almost_empty_o;
    logic [AWIDTH:0]   rd_usedw_o;
    logic              rd_underflow_o;

    modport master (
        output rd_req_i,
        input  rd_en_o, rd_addr_o, rd_empty_o, rd_almost_empty_o, rd_usedw_o, rd_underflow_o
    );

    modport slave (
        input  rd_req_i,
        output rd_en_o, rd_addr_o, rd_empty_o, rd_almost_empty_o, rd_usedw_o, rd_underflow_o
    );
endinterface

// File: rtl/sync_w2r.sv
// Two-flop synchronizer carrying the Gray write pointer into the read clock domain.
module sync_w2r #(
    parameter int unsigned W = 4
) (
    input  logic         rd_clk_i,
    input  logic         srst_i,
    input  logic [W-1:0] wr_pntr_gray_i,
    output logic [W-1:0] wq2_o
);

    logic [W-1:0] r_wq1;
    logic [W-1:0] r_wq2;

    // Only r_wq1 samples the asynchronous pointer.
    always_ff @(posedge rd_clk_i) begin
        if (srst_i) begin
            r_wq1 <= '0;
            r_wq2 <= '0;
        end else begin
            r_wq1 <= wr_pntr_gray_i;
            r_wq2 <= r_wq1;
        end
    end

    assign wq2_o = r_wq2;

endmodule

// File: rtl/rd_pntr_empty.sv
// Read-side pointer, empty/almost-empty, used-word and underflow logic of the dual-clock FIFO.
module rd_pntr_empty
    import fifo_pkg::*;
#(
    parameter int unsigned AWIDTH       = AWIDTH_DEFAULT,
    parameter int unsigned ALMOST_EMPTY = 2
) (
    input  logic             rd_clk_i,
    input  logic             srst_i,
    input  logic [AWIDTH:0]  wr_pntr_gray_rd_i,
    output logic [AWIDTH:0]  rd_pntr_gray_o,
    rd_pntr_empty_if.slave   rd_if
);

    localparam int unsigned PW = AWIDTH + 1;

    logic [PW-1:0] w_wq2;
    logic [PW-1:0] w_wr_bin;
    logic [PW-1:0] w_rd_bin_next;
    logic [PW-1:0] w_rd_gray_next;
    logic [PW-1:0] w_used;
    logic          w_rd_en;

    logic [PW-1:0] r_rd_bin;
    logic [PW-1:0] r_rd_gray;
    logic [PW-1:0] r_usedw;
    logic          r_empty;
    logic          r_almost_empty;
    logic          r_underflow;

    sync_w2r #(
        .W (PW)
    ) u_sync_w2r (
        .rd_clk_i       (rd_clk_i),
        .srst_i         (srst_i),
        .wr_pntr_gray_i (wr_pntr_gray_rd_i),
        .wq2_o          (w_wq2)
    );

    always_comb begin
        w_rd_en        = rd_if.rd_req_i & ~r_empty & ~srst_i;
        w_rd_bin_next  = r_rd_bin + PW'(w_rd_en);
        w_rd_gray_next = PW'(bin2gray(ptr_t'(w_rd_bin_next)));
        w_wr_bin       = PW'(gray2bin(ptr_t'(w_wq2)));
        // Modular difference stays within 0..2**AWIDTH while the writer respects full.
        w_used         = w_wr_bin - w_rd_bin_next;
    end

    always_ff @(posedge rd_clk_i) begin
        if (srst_i) begin
            r_rd_bin       <= '0;
            r_rd_gray      <= '0;
            r_usedw        <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_underflow    <= 1'b0;
        end else begin
            r_rd_bin       <= w_rd_bin_next;
            r_rd_gray      <= w_rd_gray_next;
            r_usedw        <= w_used;
            // Full-width compare: the MSB separates a lapped pointer from a true match.
            r_empty        <= (w_rd_gray_next == w_wq2);
            r_almost_empty <= (w_used <= PW'(ALMOST_EMPTY));
            r_underflow    <= rd_if.rd_req_i & r_empty;
        end
    end

    assign rd_pntr_gray_o          = r_rd_gray;
    assign rd_if.rd_en_o           = w_rd_en;
    assign rd_if.rd_addr_o         = r_rd_bin[AWIDTH-1:0];
    assign rd_if.rd_empty_o        = r_empty;
    assign rd_if.rd_almost_empty_o = r_almost_empty;
    assign rd_if.rd_usedw_o        = r_usedw;
    assign rd_if.rd_underflow_o    = r_underflow;

endmodule

// File: tb/tb_rd_pntr_empty.sv
// Scoreboard bench for rd_pntr_empty: integer word-count model, directed and random phases.
module tb_rd_pntr_empty;

    localparam int AW = 3;
    localparam int AE = 2;

    typedef struct {
        bit       en;
        int       addr;
        int       gray;
        bit       empty;
        bit       almost;
        int       usedw;
        bit       uf;
    } exp_t;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic [AW:0]   wr_pntr_gray_rd = '0;
    logic [AW:0]   rd_pntr_gray;

    rd_pntr_empty_if #(.AWIDTH(AW)) rd_if ();

    rd_pntr_empty #(
        .AWIDTH       (AW),
        .ALMOST_EMPTY (AE)
    ) dut (
        .rd_clk_i          (clk),
        .srst_i            (srst),
        .wr_pntr_gray_rd_i (wr_pntr_gray_rd),
        .rd_pntr_gray_o    (rd_pntr_gray),
        .rd_if             (rd_if)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model: words written/read as unbounded counts; written count seen two edges late.
    int   wr_cnt = 0;
    int   m_rd   = 0;
    int   m_seen[2] = '{0, 0};
    bit   m_empty = 1'b1;

    function automatic int gray_of(input int v);
        int m;
        m = v % 16;
        return m ^ (m >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit req);
        exp_t e;
        int   used;
        @(negedge clk);
        if (rst) wr_cnt = 0;
        srst            = rst;
        rd_if.rd_req_i  = req;
        wr_pntr_gray_rd = 4'(gray_of(wr_cnt));
        e.en   = !rst && req && !m_empty;
        e.addr = m_rd % 8;
        if (rst) begin
            m_rd    = 0;
            m_seen  = '{0, 0};
            used    = 0;
            e.uf    = 1'b0;
        end else begin
            e.uf      = req && m_empty;
            m_rd      = m_rd + (e.en ? 1 : 0);
            used      = m_seen[1] - m_rd;
            m_seen[1] = m_seen[0];
            m_seen[0] = wr_cnt;
        end
        m_empty  = (used == 0);
        e.gray   = gray_of(m_rd);
        e.empty  = m_empty;
        e.almost = (used <= AE);
        e.usedw  = used;
        sb.push_back(e);
    endtask

    // Monitor: combinational outputs mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb[0];
                chk("rd_en", int'(rd_if.rd_en_o), int'(e.en));
                chk("rd_addr", int'(rd_if.rd_addr_o), e.addr);
                @(posedge clk);
                #1;
                void'(sb.pop_front());
                chk("rd_pntr_gray", int'(rd_pntr_gray), e.gray);
                chk("rd_empty", int'(rd_if.rd_empty_o), int'(e.empty));
                chk("rd_almost_empty", int'(rd_if.rd_almost_empty_o), int'(e.almost));
                chk("rd_usedw", int'(rd_if.rd_usedw_o), e.usedw);
                chk("rd_underflow", int'(rd_if.rd_underflow_o), int'(e.uf));
            end
        end
    end

    initial begin
        int guard;
        rd_if.rd_req_i = 1'b0;

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Single word through the synchronizer, then read it.
        wr_cnt = 1;
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Fill to depth, then drain back-to-back and read once more while empty.
        wr_cnt = m_rd + 8;
        repeat (3) step(1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Steady streaming across the pointer wrap.
        repeat (60) begin
            if (wr_cnt - m_rd < 8) wr_cnt++;
            step(1'b0, 1'b1);
        end

        repeat (400) begin
            if (wr_cnt - m_rd < 8 && $urandom_range(0, 1) == 1) wr_cnt++;
            step(1'b0, $urandom_range(0, 3) != 0);
        end

        // Reset with five words held.
        wr_cnt = m_rd + 5;
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d items left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
